// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: lets two valid/ready producers share the single write port
// of a 512-deep FIFO. Ownership is handed out in bursts of up to BURST_LEN
// words and alternates round-robin when both producers are waiting. The FIFO
// write strobe and data are registered, so the first word of a burst reaches
// the FIFO one cycle after it is accepted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s0_valid/s0_data/s0_ready  requester 0 handshake
//   s1_valid/s1_data/s1_ready  requester 1 handshake
//   fifo_full, fifo_wr_count   FIFO write-side status
//   fifo_wr_en, fifo_din       registered FIFO write port
//   grant                      one-hot current owner (00 when idle)
//   burst_cnt                  words accepted in the current burst
module fifo_wr_arbiter #(
  parameter int DW        = 16,
  parameter int CW        = 9,
  parameter int BURST_LEN = 8,
  parameter int AFULL_LVL = 508
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  input  logic          fifo_full,
  input  logic [CW-1:0] fifo_wr_count,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_din,
  output logic [1:0]    grant,
  output logic [7:0]    burst_cnt
);

  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
  localparam logic [7:0]    LAST_C  = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT0 = 3'd1,
    GNT1 = 3'd2
  } state_t;

  state_t           state, state_nxt;
  logic             rr_ptr, rr_ptr_nxt;
  logic [7:0]       burst_cnt_nxt;
  logic             space;
  logic             acc;
  logic             own;
  logic [1:0]       vld;
  logic [1:0]       rdy;
  logic [1:0][DW-1:0] dat;

  assign vld = {s1_valid, s0_valid};
  assign dat = {s1_data, s0_data};

  // AFULL_LVL keeps headroom for the word still sitting in the write register.
  assign space = ~fifo_full & (fifo_wr_count < AFULL_C);

  always_comb begin
    grant = 2'b00;
    case (state)
      GNT0:    grant = 2'b01;
      GNT1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Only the owner sees ready, and only while there is room.
  assign rdy      = grant & {2{space}};
  assign s0_ready = rdy[0];
  assign s1_ready = rdy[1];
  assign acc      = |(rdy & vld);
  assign own      = grant[1];

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (space && (|vld)) begin
          // Contention resolves to rr_ptr; a lone requester wins outright.
          if (vld[0] && (!vld[1] || !rr_ptr)) state_nxt = GNT0;
          else                                state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        if ((acc && (burst_cnt == LAST_C)) || !vld[own] || !space) begin
          state_nxt     = IDLE;
          rr_ptr_nxt    = ~own;
          burst_cnt_nxt = '0;
        end else if (acc) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Registered write port; din holds its last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= acc;
      if (acc) fifo_din <= dat[own];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int DW = 16, CW = 9, BL = 8, AF = 508;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic [DW-1:0] s0_data, s1_data, fifo_din;
  logic          fifo_full, fifo_wr_en;
  logic [CW-1:0] fifo_wr_count;
  logic [1:0]    grant;
  logic [7:0]    burst_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(DW), .CW(CW), .BURST_LEN(BL), .AFULL_LVL(AF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .fifo_full(fifo_full), .fifo_wr_count(fifo_wr_count),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .grant(grant), .burst_cnt(burst_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
    fifo_full = 0; fifo_wr_count = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    bit v0, v1, full; int cnt;
    logic [1:0] g; bit r0, r1; int bc; bit wen;
  } vec_t;
  vec_t tbl[14];

  // Reference model: owner index (-1 idle), words taken, preferred requester.
  int m_owner, m_taken, m_pref;
  bit m_wr;
  logic [DW-1:0] m_din;

  initial begin
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_w;
    int k, cyc, first, d0, d1;
    bit sp, vo;

    // ---------------- reset with s0 requesting ----------------
    s0_valid = 1; s1_valid = 0; s0_data = 16'h00AA; s1_data = '0;
    fifo_full = 0; fifo_wr_count = '0; rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_grant", grant, 0);
      chk("rst_s0_ready", s0_ready, 0);
      chk("rst_din", fifo_din, 0);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("post_rst_idle", grant, 2'b00);
    @(negedge clk); chk("post_rst_gnt0", {grant, s0_ready, fifo_wr_en}, {2'b01, 1'b1, 1'b0});
    @(negedge clk); chk("post_rst_first_wr", {fifo_wr_en, fifo_din}, {1'b1, 16'h00AA});

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{1,1,0,0,   2'b00,0,0,0,0};
    tbl[1]  = '{1,1,0,0,   2'b01,1,0,0,0};
    tbl[2]  = '{1,1,0,0,   2'b01,1,0,1,1};
    tbl[3]  = '{1,1,0,0,   2'b01,1,0,2,1};
    tbl[4]  = '{0,1,0,0,   2'b01,1,0,3,1};
    tbl[5]  = '{1,1,0,0,   2'b00,0,0,0,0};
    tbl[6]  = '{1,1,0,0,   2'b10,0,1,0,0};
    tbl[7]  = '{1,1,0,508, 2'b10,0,0,1,1};
    tbl[8]  = '{1,1,0,508, 2'b00,0,0,0,0};
    tbl[9]  = '{1,0,0,507, 2'b00,0,0,0,0};
    tbl[10] = '{1,0,1,0,   2'b01,0,0,0,0};
    tbl[11] = '{1,0,0,0,   2'b00,0,0,0,0};
    tbl[12] = '{0,1,0,0,   2'b01,1,0,0,0};
    tbl[13] = '{0,0,0,0,   2'b00,0,0,0,0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      s0_valid = tbl[i].v0; s1_valid = tbl[i].v1; fifo_full = tbl[i].full;
      fifo_wr_count = CW'(tbl[i].cnt);
      s0_data = 16'(i); s1_data = 16'(16'h100 + i);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {grant, s0_ready, s1_ready, burst_cnt, fifo_wr_en},
          {tbl[i].g, tbl[i].r0, tbl[i].r1, 8'(tbl[i].bc), tbl[i].wen});
      @(posedge clk); #1;
    end

    // ---------------- single requester, 24 words ----------------
    do_reset();
    wq.delete(); k = 0; cyc = 0; first = -1;
    s1_valid = 1; s1_data = 0;
    while (k < 24 && cyc < 100) begin
      @(negedge clk);
      if (fifo_wr_en) wq.push_back(fifo_din);
      chk("single_s0_ready", s0_ready, 0);
      if (s1_ready) begin
        if (first < 0) first = cyc;
        chk("single_accept_cycle", cyc - first, k + k / BL);
        chk("single_grant", grant, 2'b10);
        k++;
      end
      @(posedge clk); #1;
      s1_data = 16'(k);
      cyc++;
    end
    s1_valid = 0;
    @(negedge clk); if (fifo_wr_en) wq.push_back(fifo_din);
    chk("single_count", wq.size(), 24);
    for (int i = 0; i < wq.size() && i < 24; i++) chk("single_data", wq[i], i);

    // ---------------- round robin ----------------
    do_reset();
    wq.delete(); cyc = 0; d0 = 0; d1 = 0;
    s0_valid = 1; s1_valid = 1; s0_data = 16'h0000; s1_data = 16'h1000;
    while (wq.size() < 32 && cyc < 200) begin
      @(negedge clk);
      if (fifo_wr_en) wq.push_back(fifo_din);
      if (s0_ready && s1_ready) chk("rr_both_ready", 1, 0);
      if (s0_ready) d0++;
      if (s1_ready) d1++;
      @(posedge clk); #1;
      s0_data = 16'(d0); s1_data = 16'(16'h1000 + d1);
      cyc++;
    end
    chk("rr_count", wq.size(), 32);
    for (int i = 0; i < wq.size() && i < 32; i++) begin
      exp_w = 16'(((i / BL) % 2 ? 16'h1000 : 0) + (i / (2 * BL)) * BL + (i % BL));
      chk($sformatf("rr_word%0d", i), wq[i], exp_w);
    end

    // ---------------- reset mid-burst at burst_cnt=5 ----------------
    do_reset();
    s0_valid = 1; s0_data = 16'h5000; cyc = 0;
    @(negedge clk);
    while (burst_cnt != 8'd5 && cyc < 20) begin
      @(posedge clk); #1 s0_data = s0_data + 16'd1;
      @(negedge clk);
      cyc++;
    end
    chk("midrst_reached5", burst_cnt, 5);
    rst_n = 0; #1;
    chk("midrst_outputs", {grant, burst_cnt, fifo_wr_en, s0_ready}, 12'd0);
    s1_valid = 1;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("midrst_idle", grant, 2'b00);
    @(negedge clk); chk("midrst_rr0", grant, 2'b01);

    // ---------------- randomized against model ----------------
    do_reset();
    m_owner = -1; m_taken = 0; m_pref = 0; m_wr = 0; m_din = '0;
    for (int c = 0; c < 2000; c++) begin
      s0_valid = ($urandom_range(0, 7) != 0);
      s1_valid = ($urandom_range(0, 7) != 0);
      s0_data = 16'($urandom); s1_data = 16'($urandom);
      fifo_full = ($urandom_range(0, 31) == 0);
      fifo_wr_count = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(505, 511))
                                                  : CW'($urandom_range(0, 504));
      @(negedge clk);
      sp = !fifo_full && (int'(fifo_wr_count) < AF);
      chk("rnd_grant", grant, m_owner < 0 ? 0 : (m_owner == 0 ? 1 : 2));
      chk("rnd_s0_ready", s0_ready, (m_owner == 0) && sp);
      chk("rnd_s1_ready", s1_ready, (m_owner == 1) && sp);
      chk("rnd_burst_cnt", burst_cnt, m_taken);
      chk("rnd_wr_en", fifo_wr_en, m_wr);
      if (m_wr) chk("rnd_din", fifo_din, m_din);
      // advance model across the coming edge
      if (m_owner < 0) begin
        m_wr = 0;
        if (sp && (s0_valid || s1_valid)) begin
          m_owner = (s0_valid && s1_valid) ? m_pref : (s0_valid ? 0 : 1);
          m_taken = 0;
        end
      end else begin
        vo = (m_owner == 0) ? s0_valid : s1_valid;
        if (vo && sp) begin
          m_wr = 1;
          m_din = (m_owner == 0) ? s0_data : s1_data;
          m_taken++;
        end else m_wr = 0;
        if (!(vo && sp) || m_taken == BL) begin
          m_pref = 1 - m_owner; m_owner = -1; m_taken = 0;
        end
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Two-requester write arbiter that shares the single write port of the 16-bit async-capable FIFO IP (512 deep, 9-bit wr_data_count) between two producers. Each producer uses a valid/ready handshake. Grants are issued in bounded bursts with round-robin fairness. The FIFO write side is driven from registers, and almost-full throttling keeps the FIFO from overflowing.

Parameters:
DW, 16, data width of requester and FIFO data
CW, 9, width of FIFO wr_data_count
BURST_LEN, 8, max words accepted per grant (1..255)
AFULL_LVL, 508, stop accepting when wr_data_count >= AFULL_LVL

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous reset, active-low
s0_valid  in  1  requester 0 has a word
s0_data  in  DW  requester 0 word
s0_ready  out  1  requester 0 word accepted this cycle when s0_valid&s0_ready
s1_valid  in  1  requester 1 has a word
s1_data  in  DW  requester 1 word
s1_ready  out  1  requester 1 handshake
fifo_full  in  1  FIFO full flag
fifo_wr_count  in  CW  FIFO wr_data_count
fifo_wr_en  out  1  FIFO write enable (registered)
fifo_din  out  DW  FIFO write data (registered)
grant  out  2  one-hot current owner, 2'b00 when idle
burst_cnt  out  8  words accepted in current burst

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0 (requester 0 preferred), grant=0, burst_cnt=0, fifo_wr_en=0, fifo_din=0, s0_ready=s1_ready=0.
- States: IDLE, GNT0, GNT1 (3-bit encoding; undefined codes go to IDLE).
- space = ~fifo_full & (fifo_wr_count < AFULL_LVL).
- IDLE: if space and any valid, pick the owner. If both valid, take rr_ptr; otherwise take whichever is valid. Enter GNTn next cycle with burst_cnt=0. IDLE never accepts data.
- GNTn: sn_ready = space (combinational). Other requester's ready = 0. Accept = sn_valid & sn_ready; each accept increments burst_cnt.
- Burst end, evaluated on each cycle in GNTn, with the first matching condition taking effect:
  - (a) accept with burst_cnt==BURST_LEN-1;
  - (b) sn_valid==0;
  - (c) space==0.
  - Next state is IDLE, rr_ptr = ~n, burst_cnt cleared on IDLE entry.
  - In case (a) the final word is still accepted.
- Write path, 1-cycle latency: on the clock edge after an accept, fifo_wr_en=1 and fifo_din=accepted word. Otherwise fifo_wr_en=0 and fifo_din holds its last value.
- AFULL_LVL leaves at least 2 entries of margin for the in-flight registered write. fifo_wr_en must never assert while fifo_full=1 given correct AFULL_LVL.
- grant reflects state: GNT0→2'b01, GNT1→2'b10, IDLE→2'b00.
- Fairness: with both requesters continuously valid and space, grants alternate, each burst is exactly BURST_LEN words, and there is one IDLE cycle between bursts.
- sn_data is sampled only on accept; data changes while not accepted are ignored.
- Reset mid-burst: all outputs return to reset values immediately. A word accepted in the cycle before reset is dropped (fifo_wr_en cleared).

Test Plan:
- Reset: rst_n=0 for 3 cycles with s0_valid=1 → fifo_wr_en=0, grant=00, s0_ready=0; release → GNT0 one cycle after IDLE, first fifo_wr_en one cycle after first accept.
- Single requester: s1_valid=1 continuous, data 0..23, BURST_LEN=8 → three bursts of 8 (grant=10) separated by one IDLE cycle; FIFO receives 0..23 in order, no gaps within bursts.
- Round-robin: both valid continuously, s0 data 0x0000+, s1 data 0x1000+ → FIFO sequence 0x0000..7, 0x1000..7, 0x0008..F, 0x1008..F.
- Early release: s0 drops valid after 3 words while s1 valid → burst_cnt stops at 3, next grant=10.
- Almost-full: drive fifo_wr_count to 508 mid-burst → ready deasserts the same cycle, state→IDLE, no accept until count<508; fifo_full=1 → zero fifo_wr_en.
- Reset mid-burst at burst_cnt=5 → grant=00, burst_cnt=0, fifo_wr_en=0 within the reset cycle; resumes with rr_ptr=0.
